decoder_seq: RTL and testbench
==============================

DECODER_SEQ -- requirements
Module: decoder_seq

Interface
REQ-001 The block SHALL have parameter N, default 3, giving the select width (legal range 1..6).
REQ-002 The block SHALL have derived parameter M = 2**N, giving the output width; it SHALL NOT be overridden.
REQ-003 The block SHALL have port clk, input, 1, the single clock; all state SHALL update on its rising edge.
REQ-004 The block SHALL have port rst_n, input, 1, reset that is asynchronous and active-low.
REQ-005 The block SHALL have port ena, input, 1, output enable; it SHALL also gate step.
REQ-006 The block SHALL have port mode, input, 1: 0 = direct decode, 1 = sweep.
REQ-007 The block SHALL have port load, input, 1: index <= in.
REQ-008 The block SHALL have port in, input, N, the index to load.
REQ-009 The block SHALL have port step, input, 1: advance the index, sweep mode only.
REQ-010 The block SHALL have port out, output, M, the registered one-hot decode of the index.
REQ-011 The block SHALL have port idx, output, N, the current index register.
REQ-012 The block SHALL have port wrap, output, 1, a one-cycle pulse on a sweep end event.

Function
REQ-013 The block SHALL hold an internal index register idx (N bits); idx_next SHALL be computed each cycle and registered.
REQ-014 Priority SHALL be: load > step > hold. When load=1, idx_next = in, regardless of ena and mode.
REQ-015 Step SHALL be honoured only when load=0, step=1, ena=1 and mode=1; otherwise step SHALL be ignored.
REQ-016 Default sweep (wrap mode): idx_next = idx+1 modulo M; M-1 -> 0 SHALL assert wrap for exactly one cycle.
REQ-017 When mode=0, idx SHALL change only via load, and wrap SHALL stay 0.
REQ-018 On each edge, out SHALL be set to (1 << idx_next) if ena=1, else all-zero; latency from load/step/ena to out SHALL be 1 cycle.
REQ-019 out SHALL always be one-hot or all-zero; no other pattern is legal.
REQ-020 wrap SHALL be registered and aligned with the out value that shows the post-wrap index.
REQ-021 Load coincident with a would-be wrap SHALL suppress wrap, and idx SHALL take the value of in.
REQ-022 Changing mode mid-sweep SHALL take effect at the next edge, with no reset of idx.

Reset
REQ-023 While rst_n=0, asynchronously: idx = 0, out = all-zero, wrap = 0, and direction register dir = up.
REQ-024 On rst_n deassertion, the first edge SHALL behave per REQ-014..REQ-018; reset asserted mid-sweep SHALL abort the sweep immediately.

Configuration
REQ-025 Macro DECODER_SEQ_BOUNCE_EN defined: sweep SHALL ping-pong, with a 1-bit dir register (reset up).
REQ-026 Under bounce, up SHALL run idx+1 until M-1, then reverse; down SHALL run idx-1 until 0, then reverse.
REQ-027 Under bounce, wrap SHALL pulse on each reversal: the step that leaves M-1 going down, and the step that leaves 0 going up.
REQ-028 Under bounce, load SHALL set idx and leave dir unchanged.
REQ-029 Under bounce with N=1, sweep SHALL alternate 0,1,0,...
REQ-030 Macro undefined: the dir register SHALL be absent, and behaviour SHALL be per REQ-016.

Verification
REQ-031 The bench SHALL cover, with N=3, ena=0 and load=1 with in=5: idx=5 next cycle and out=8'h00; then ena=1 -> out=8'h20 one cycle later.
REQ-032 The bench SHALL cover, with N=3, mode=1, ena=1 and load of 6, then step x2: out 8'h40 -> 8'h80 -> 8'h01, with wrap=1 only on the 8'h01 cycle.
REQ-033 The bench SHALL cover, with N=3 at idx=7, load=1 with in=2 and step=1 together: out=8'h04, wrap=0.
REQ-034 The bench SHALL cover, with N=3, mode=0 and step held high for 10 cycles: idx constant, wrap never 1.
REQ-035 The bench SHALL cover, with N=3 mid-sweep at idx=4, rst_n pulsed low between edges: out=0 and idx=0 immediately, and not at the next edge.
REQ-036 The bench SHALL cover, with N=2 and BOUNCE_EN, from reset stepping 7 times: idx 1,2,3,2,1,0,1, with wrap on the idx=2 (first) and idx=1 (second) cycles.

Source files
------------

// File: rtl/decoder_seq.sv
// Sequenced one-hot decoder: loadable index with optional sweep, registered decode and wrap pulse.
// Define DECODER_SEQ_BOUNCE_EN to make the sweep ping-pong between 0 and M-1 instead of wrapping.
module decoder_seq #(
   parameter int unsigned N = 3
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             ena,
   input  logic             mode,
   input  logic             load,
   input  logic [N-1:0]     in,
   input  logic             step,
   output logic [(2**N)-1:0] out,
   output logic [N-1:0]     idx,
   output logic             wrap
);

   localparam int unsigned M = 2 ** N;
   localparam logic [N-1:0] IDX_MAX = N'(M - 1);
   localparam logic [N-1:0] IDX_ONE = N'(1);

   logic [N-1:0] idx_q, idx_d;
   logic [M-1:0] out_q, out_d;
   logic         wrap_q, wrap_d;
   logic         step_ok;

`ifdef DECODER_SEQ_BOUNCE_EN
   typedef enum logic {DIR_UP = 1'b0, DIR_DOWN = 1'b1} dir_e;
   dir_e dir_q, dir_d;
`endif

   // Next index: load wins over step; step only counts while enabled in sweep mode.
   always_comb begin
      idx_d   = idx_q;
      wrap_d  = 1'b0;
      step_ok = !load && step && ena && mode;
`ifdef DECODER_SEQ_BOUNCE_EN
      dir_d   = dir_q;
`endif
      if (load) begin
         idx_d = in;
      end else if (step_ok) begin
`ifdef DECODER_SEQ_BOUNCE_EN
         if (dir_q == DIR_UP) begin
            if (idx_q == IDX_MAX) begin
               idx_d  = idx_q - IDX_ONE;
               dir_d  = DIR_DOWN;
               wrap_d = 1'b1;
            end else begin
               idx_d = idx_q + IDX_ONE;
            end
         end else begin
            if (idx_q == '0) begin
               idx_d  = idx_q + IDX_ONE;
               dir_d  = DIR_UP;
               wrap_d = 1'b1;
            end else begin
               idx_d = idx_q - IDX_ONE;
            end
         end
`else
         idx_d  = idx_q + IDX_ONE;
         wrap_d = (idx_q == IDX_MAX);
`endif
      end
      out_d = ena ? (M'(1) << idx_d) : '0;
   end

   // State and registered outputs; reset aborts any sweep immediately.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         idx_q  <= '0;
         out_q  <= '0;
         wrap_q <= 1'b0;
`ifdef DECODER_SEQ_BOUNCE_EN
         dir_q  <= DIR_UP;
`endif
      end else begin
         idx_q  <= idx_d;
         out_q  <= out_d;
         wrap_q <= wrap_d;
`ifdef DECODER_SEQ_BOUNCE_EN
         dir_q  <= dir_d;
`endif
      end
   end

   assign out  = out_q;
   assign idx  = idx_q;
   assign wrap = wrap_q;

endmodule

// File: tb/tb_decoder_seq.sv
// Directed self-checking bench for decoder_seq: N=3 main instance plus an N=2 sweep instance.
module tb_decoder_seq;

   logic       clk = 1'b0;
   logic       rst_n;
   logic       ena, mode, load, step;
   logic [2:0] in_v;
   logic [7:0] out;
   logic [2:0] idx;
   logic       wrap;

   logic       ena2, mode2, load2, step2;
   logic [1:0] in2;
   logic [3:0] out2;
   logic [1:0] idx2;
   logic       wrap2;

   int errors = 0;
   int checks = 0;
   int exp_idx2 [7];
   int exp_wrap2 [7];

   always #5 clk = ~clk;

   decoder_seq #(.N(3)) u_dut (
      .clk(clk), .rst_n(rst_n), .ena(ena), .mode(mode), .load(load),
      .in(in_v), .step(step), .out(out), .idx(idx), .wrap(wrap)
   );

   decoder_seq #(.N(2)) u_dut2 (
      .clk(clk), .rst_n(rst_n), .ena(ena2), .mode(mode2), .load(load2),
      .in(in2), .step(step2), .out(out2), .idx(idx2), .wrap(wrap2)
   );

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp_v);
      checks++;
      assert (obs === exp_v) else begin
         errors++;
         $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp_v);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   initial begin
`ifdef DECODER_SEQ_BOUNCE_EN
      exp_idx2  = '{1, 2, 3, 2, 1, 0, 1};
      exp_wrap2 = '{0, 0, 0, 1, 0, 0, 1};
`else
      exp_idx2  = '{1, 2, 3, 0, 1, 2, 3};
      exp_wrap2 = '{0, 0, 0, 1, 0, 0, 0};
`endif
      rst_n = 1'b0;
      ena = 0; mode = 0; load = 0; step = 0; in_v = 3'd0;
      ena2 = 0; mode2 = 0; load2 = 0; step2 = 0; in2 = 2'd0;
      tick(); tick();
      chk("rst_out", 32'(out), 32'h00);
      chk("rst_idx", 32'(idx), 32'd0);
      chk("rst_wrap", 32'(wrap), 32'd0);
      rst_n = 1'b1;

      // Load while disabled, then enable
      ena = 0; load = 1; in_v = 3'd5;
      tick();
      chk("ld5_idx", 32'(idx), 32'd5);
      chk("ld5_out_dis", 32'(out), 32'h00);
      load = 0; ena = 1;
      tick();
      chk("ld5_out_en", 32'(out), 32'h20);

      // Sweep across the top with wrap
      mode = 1; load = 1; in_v = 3'd6;
      tick();
      chk("sw_out6", 32'(out), 32'h40);
      chk("sw_wrap6", 32'(wrap), 32'd0);
      load = 0; step = 1;
      tick();
      chk("sw_out7", 32'(out), 32'h80);
      chk("sw_wrap7", 32'(wrap), 32'd0);
      tick();
      chk("sw_out0", 32'(out), 32'h01);
      chk("sw_wrap0", 32'(wrap), 32'd1);
      chk("sw_idx0", 32'(idx), 32'd0);
      step = 0;
      tick();
      chk("sw_wrap_pulse", 32'(wrap), 32'd0);
      chk("sw_hold_out", 32'(out), 32'h01);

      // Load beats a would-be wrap
      load = 1; in_v = 3'd7;
      tick();
      chk("lw_idx7", 32'(idx), 32'd7);
      in_v = 3'd2; step = 1;
      tick();
      chk("lw_out", 32'(out), 32'h04);
      chk("lw_wrap", 32'(wrap), 32'd0);
      chk("lw_idx", 32'(idx), 32'd2);
      load = 0;

      // Direct mode ignores step
      mode = 0; step = 1;
      for (int i = 0; i < 10; i++) begin
         tick();
         chk("dm_idx", 32'(idx), 32'd2);
         chk("dm_wrap", 32'(wrap), 32'd0);
      end

      // Mode change takes effect at the next edge without resetting idx
      mode = 1;
      tick();
      chk("mc_idx", 32'(idx), 32'd3);
      chk("mc_out", 32'(out), 32'h08);

      // Step gated by ena, out forced to zero
      ena = 0;
      tick();
      chk("eg_idx", 32'(idx), 32'd3);
      chk("eg_out", 32'(out), 32'h00);
      ena = 1;
      tick();
      chk("eg_resume_idx", 32'(idx), 32'd4);
      chk("eg_resume_out", 32'(out), 32'h10);

      // Asynchronous reset mid-sweep at idx=4
      #3;
      rst_n = 1'b0;
      #1;
      chk("ar_out", 32'(out), 32'h00);
      chk("ar_idx", 32'(idx), 32'd0);
      chk("ar_wrap", 32'(wrap), 32'd0);
      tick();
      chk("ar_hold_idx", 32'(idx), 32'd0);
      rst_n = 1'b1;
      tick();
      chk("ar_first_idx", 32'(idx), 32'd1);
      chk("ar_first_out", 32'(out), 32'h02);
      step = 0; mode = 0; ena = 0;

      // N=2 sweep from reset
      rst_n = 1'b0;
      tick();
      rst_n = 1'b1;
      ena2 = 1; mode2 = 1; step2 = 1;
      for (int i = 0; i < 7; i++) begin
         tick();
         chk("n2_idx", 32'(idx2), 32'(exp_idx2[i]));
         chk("n2_out", 32'(out2), 32'(1) << exp_idx2[i]);
         chk("n2_wrap", 32'(wrap2), 32'(exp_wrap2[i]));
      end
      step2 = 0;

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
